// File: rtl/ofm_pkg.sv
// Shared constants, packer state encoding and lane geometry for the OFM
// byte-addressed read/write ports.
package ofm_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int LANES  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } packer_state_e;

  // Big-endian lane placement: lane 0 occupies the most significant byte.
  function automatic logic [4:0] lane_offset(input logic [1:0] lane);
    return 5'(WORD_W - 1 - BYTE_W * int'(lane));
  endfunction

endpackage

// File: rtl/lane_packer.sv
// Staging register and lane counter: merges the incoming byte into the
// current lane and reports when the next accepted byte completes a word.
module lane_packer
  import ofm_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                accept,
  input  logic                wrap,
  input  logic [BYTE_W-1:0]   byte_data,
  output logic                word_full,
  output logic [WORD_W-1:0]   word_next
);

  logic [WORD_W-1:0] staging_q, staging_d;
  logic [1:0]        lane_q, lane_d;

  assign word_full = (lane_q == 2'(LANES - 1));

  always_comb begin
    word_next = staging_q;
    word_next[lane_offset(lane_q) -: BYTE_W] = byte_data;
  end

  // A wrap hands word_next to the write port, so staging restarts empty.
  always_comb begin
    staging_d = staging_q;
    lane_d    = lane_q;
    if (clear) begin
      staging_d = '0;
      lane_d    = '0;
    end else if (accept) begin
      if (wrap) begin
        staging_d = '0;
        lane_d    = '0;
      end else begin
        staging_d = word_next;
        lane_d    = lane_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      staging_q <= '0;
      lane_q    <= '0;
    end else begin
      staging_q <= staging_d;
      lane_q    <= lane_d;
    end
  end

endmodule

// File: rtl/ofm_byte_packer.sv
// Packs a byte stream big-endian into 32-bit words for the OFM memory write
// port. Optional byte_count output enabled by OFM_PACKER_BYTE_COUNT_EN.
module ofm_byte_packer
  import ofm_pkg::*;
#(
  parameter int SIZE = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                byte_valid,
  input  logic [BYTE_W-1:0]   byte_data,
  input  logic                byte_last,
  output logic                byte_ready,
  output logic                we,
  output logic [7:0]          write_addr,
  output logic [WORD_W-1:0]   datai,
  output logic                done,
  output logic                overflow,
`ifdef OFM_PACKER_BYTE_COUNT_EN
  output logic [10:0]         byte_count,
`endif
  output packer_state_e       dbg_state
);

  localparam logic [8:0] SIZE_P = 9'(SIZE);

  packer_state_e     state_q, state_d;
  logic [8:0]        ptr_q, ptr_d;
  logic              ready_q, ready_d;
  logic              we_q, we_d;
  logic [7:0]        addr_q, addr_d;
  logic [WORD_W-1:0] datai_q, datai_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              accept_c, wrap_c, full_c;
  logic              word_full;
  logic [WORD_W-1:0] word_next;

  lane_packer u_lane_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (start),
    .accept    (accept_c),
    .wrap      (wrap_c),
    .byte_data (byte_data),
    .word_full (word_full),
    .word_next (word_next)
  );

  assign full_c = (ptr_q == SIZE_P);

  // Handshake: a byte transfers on a rising edge where byte_valid && byte_ready;
  // byte_ready is registered and never depends on byte_valid in the same cycle.
  // FLUSH is the cycle the frame's final word sits on the write port.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    datai_d  = datai_q;
    ovf_d    = ovf_q;
    accept_c = 1'b0;
    wrap_c   = 1'b0;
    if (start) begin
      state_d = FILL;
      ptr_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        FILL: begin
          if (byte_valid && full_c) begin
            ovf_d = 1'b1;
            if (byte_last) state_d = DONE;
          end else if (byte_valid && ready_q) begin
            accept_c = 1'b1;
            if (byte_last || word_full) begin
              wrap_c  = 1'b1;
              we_d    = 1'b1;
              addr_d  = ptr_q[7:0];
              datai_d = word_next;
              ptr_d   = ptr_q + 9'd1;
            end
            if (byte_last) state_d = FLUSH;
          end
        end
        FLUSH:   state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    ready_d = (state_d == FILL) && (ptr_d != SIZE_P);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      datai_q <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      datai_q <= datai_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef OFM_PACKER_BYTE_COUNT_EN
  logic [10:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (start)         count_d = '0;
    else if (accept_c) count_d = count_q + 11'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign byte_count = count_q;
`endif

  assign byte_ready = ready_q;
  assign we         = we_q;
  assign write_addr = addr_q;
  assign datai      = datai_q;
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ofm_byte_packer.sv
// Directed bench for ofm_byte_packer: a SIZE=128 instance driven from a
// cycle table, and a SIZE=2 instance for the full/overflow/restart corners.
module tb_ofm_byte_packer;
  import ofm_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          a_start = 0, a_valid = 0, a_last = 0;
  logic [7:0]    a_data = 0;
  logic          a_ready, a_we, a_done, a_ovf;
  logic [7:0]    a_addr;
  logic [31:0]   a_datai;
  packer_state_e a_state;

  logic          b_start = 0, b_valid = 0, b_last = 0;
  logic [7:0]    b_data = 0;
  logic          b_ready, b_we, b_done, b_ovf;
  logic [7:0]    b_addr;
  logic [31:0]   b_datai;
  packer_state_e b_state;

`ifdef OFM_PACKER_BYTE_COUNT_EN
  logic [10:0]   a_count, b_count;
`endif

  ofm_byte_packer #(.SIZE(128)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .byte_valid(a_valid),
    .byte_data(a_data), .byte_last(a_last), .byte_ready(a_ready),
    .we(a_we), .write_addr(a_addr), .datai(a_datai), .done(a_done),
    .overflow(a_ovf),
`ifdef OFM_PACKER_BYTE_COUNT_EN
    .byte_count(a_count),
`endif
    .dbg_state(a_state)
  );

  ofm_byte_packer #(.SIZE(2)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .byte_valid(b_valid),
    .byte_data(b_data), .byte_last(b_last), .byte_ready(b_ready),
    .we(b_we), .write_addr(b_addr), .datai(b_datai), .done(b_done),
    .overflow(b_ovf),
`ifdef OFM_PACKER_BYTE_COUNT_EN
    .byte_count(b_count),
`endif
    .dbg_state(b_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic s, input logic v, input logic [7:0] d, input logic l);
    @(negedge clk);
    a_start = s; a_valid = v; a_data = d; a_last = l;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input logic s, input logic v, input logic [7:0] d, input logic l);
    @(negedge clk);
    b_start = s; b_valid = v; b_data = d; b_last = l;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        s;
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        rdy;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        dn;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, input logic v, input logic [7:0] d, input logic l,
                              input logic rdy, input logic we, input logic [7:0] addr,
                              input logic [31:0] data, input logic dn);
    vec_t r;
    r.s = s; r.v = v; r.d = d; r.l = l;
    r.rdy = rdy; r.we = we; r.addr = addr; r.data = data; r.dn = dn;
    return r;
  endfunction

  initial begin
    // Expected outputs are those seen just after the edge that samples the inputs.
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 0, 8'h00, 32'h0, 0));
    vecs.push_back(mk(0, 1, 8'h11, 0, 1, 0, 8'h00, 32'h0, 0));
    vecs.push_back(mk(0, 1, 8'h22, 0, 1, 0, 8'h00, 32'h0, 0));
    vecs.push_back(mk(0, 1, 8'h33, 0, 1, 0, 8'h00, 32'h0, 0));
    vecs.push_back(mk(0, 1, 8'h44, 1, 0, 1, 8'h00, 32'h11223344, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 32'h0, 1));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 32'h0, 0));
    vecs.push_back(mk(0, 1, 8'hCC, 0, 0, 0, 8'h00, 32'h0, 0));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 0, 8'h00, 32'h0, 0));
    vecs.push_back(mk(0, 1, 8'hA0, 0, 1, 0, 8'h00, 32'h0, 0));
    vecs.push_back(mk(0, 1, 8'hA1, 0, 1, 0, 8'h00, 32'h0, 0));
    vecs.push_back(mk(0, 1, 8'hA2, 0, 1, 0, 8'h00, 32'h0, 0));
    vecs.push_back(mk(0, 1, 8'hA3, 0, 1, 1, 8'h00, 32'hA0A1A2A3, 0));
    vecs.push_back(mk(0, 1, 8'hA4, 0, 1, 0, 8'h00, 32'h0, 0));
    vecs.push_back(mk(0, 1, 8'hA5, 1, 0, 1, 8'h01, 32'hA4A50000, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 32'h0, 1));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 32'h0, 0));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 0, 8'h00, 32'h0, 0));
    vecs.push_back(mk(0, 1, 8'hB0, 0, 1, 0, 8'h00, 32'h0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 8'h00, 32'h0, 0));
    vecs.push_back(mk(0, 1, 8'hB1, 1, 0, 1, 8'h00, 32'hB0B10000, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 32'h0, 1));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 0, 8'h00, 32'h0, 0));
    vecs.push_back(mk(0, 1, 8'hC7, 1, 0, 1, 8'h00, 32'hC7000000, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 32'h0, 1));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 32'h0, 0));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst ready", a_ready, 0);
    chk("rst we", a_we, 0);
    chk("rst addr", a_addr, 0);
    chk("rst datai", a_datai, 0);
    chk("rst done", a_done, 0);
    chk("rst overflow", a_ovf, 0);
    chk("rst state", a_state, IDLE);
`ifdef OFM_PACKER_BYTE_COUNT_EN
    chk("rst byte_count", a_count, 0);
`endif
    @(negedge clk);
    rst = 1'b1;

    // Table-driven frames on the SIZE=128 instance
    for (int i = 0; i < vecs.size(); i++) begin
      drive_a(vecs[i].s, vecs[i].v, vecs[i].d, vecs[i].l);
      chk($sformatf("vec%0d ready", i), a_ready, vecs[i].rdy);
      chk($sformatf("vec%0d we", i), a_we, vecs[i].we);
      chk($sformatf("vec%0d done", i), a_done, vecs[i].dn);
      if (vecs[i].we) begin
        chk($sformatf("vec%0d addr", i), a_addr, vecs[i].addr);
        chk($sformatf("vec%0d datai", i), a_datai, vecs[i].data);
      end
    end
    chk("table overflow", a_ovf, 0);

    // Asynchronous reset mid-frame, then no writes until a new start
    drive_a(1, 0, 8'h00, 0);
    drive_a(0, 1, 8'h51, 0);
    drive_a(0, 1, 8'h52, 0);
    drive_a(0, 1, 8'h53, 0);
    a_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async rst ready", a_ready, 0);
    chk("async rst datai", a_datai, 0);
    chk("async rst we", a_we, 0);
    chk("async rst done", a_done, 0);
    chk("async rst state", a_state, IDLE);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive_a(0, 1, 8'(8'h54 + k), k == 4);
      chk($sformatf("post rst we%0d", k), a_we, 0);
      chk($sformatf("post rst ready%0d", k), a_ready, 0);
    end

`ifdef OFM_PACKER_BYTE_COUNT_EN
    drive_a(1, 0, 8'h00, 0);
    chk("count after start", a_count, 0);
    for (int k = 0; k < 5; k++) drive_a(0, 1, 8'(k + 1), k == 4);
    chk("count flush we", a_we, 1);
    chk("count flush datai", a_datai, 32'h05000000);
    drive_a(0, 0, 8'h00, 0);
    chk("count done", a_done, 1);
    chk("count at done", a_count, 5);
    for (int k = 0; k < 3; k++) drive_a(0, 1, 8'hEE, 0);
    chk("count held", a_count, 5);
`endif

    // SIZE=2: fill both words, then overflow
    drive_b(1, 0, 8'h00, 0);
    chk("b start ready", b_ready, 1);
    for (int k = 0; k < 9; k++) begin
      drive_b(0, 1, 8'(8'h60 + k), 0);
      chk($sformatf("b byte%0d we", k), b_we, (k == 3 || k == 7));
      chk($sformatf("b byte%0d ready", k), b_ready, (k < 7));
      chk($sformatf("b byte%0d overflow", k), b_ovf, (k == 8));
      if (k == 3) begin
        chk("b word0 addr", b_addr, 0);
        chk("b word0 datai", b_datai, 32'h60616263);
      end
      if (k == 7) begin
        chk("b word1 addr", b_addr, 1);
        chk("b word1 datai", b_datai, 32'h64656667);
      end
    end
    for (int k = 0; k < 2; k++) begin
      drive_b(0, 1, 8'h70, 0);
      chk($sformatf("b full we%0d", k), b_we, 0);
      chk($sformatf("b sticky overflow%0d", k), b_ovf, 1);
    end
    drive_b(0, 1, 8'h99, 1);
    chk("b last while full done", b_done, 1);
    chk("b last while full we", b_we, 0);
    chk("b last while full state", b_state, DONE);
    drive_b(0, 0, 8'h00, 0);
    chk("b done pulse ends", b_done, 0);
    chk("b back to idle", b_state, IDLE);

    // Restart mid-word: only bytes after the second start land in word 0
    drive_b(1, 0, 8'h00, 0);
    chk("b restart overflow cleared", b_ovf, 0);
    drive_b(0, 1, 8'h01, 0);
    drive_b(0, 1, 8'h02, 0);
    drive_b(1, 0, 8'h00, 0);
    chk("b restart ready", b_ready, 1);
    for (int k = 0; k < 4; k++) drive_b(0, 1, 8'(8'hD0 + k), 0);
    chk("b restart we", b_we, 1);
    chk("b restart addr", b_addr, 0);
    chk("b restart datai", b_datai, 32'hD0D1D2D3);
    chk("b restart overflow", b_ovf, 0);
`ifdef OFM_PACKER_BYTE_COUNT_EN
    chk("b restart count", b_count, 4);
`endif
    drive_b(0, 0, 8'h00, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
